// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Fetch-to-decode bus used by hazard_scoreboard. It bundles everything
//   except clock and reset.
//
//   Signals driven by fetch (master):
//     inst_in, inst_vld           fetched instruction and its valid flag
//     rs_idx/rs_use, rt_idx/rt_use source registers and whether each is read
//     wr_idx/wr_en                destination register and write flag
//     is_load, is_ctrl, is_halt   instruction class flags
//
//   Signals driven by the scoreboard (slave):
//     inst_out   instruction forwarded to decode (NOP on a bubble)
//     pcNop      hold the PC this cycle
//     issue      inst_in accepted this cycle
//     halted     halt latched
//     sb_occ     number of valid scoreboard entries
interface hazard_scoreboard_if #(
  parameter int INST_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] inst_in;
  logic              inst_vld;
  logic [REG_W-1:0]  rs_idx;
  logic              rs_use;
  logic [REG_W-1:0]  rt_idx;
  logic              rt_use;
  logic [REG_W-1:0]  wr_idx;
  logic              wr_en;
  logic              is_load;
  logic              is_ctrl;
  logic              is_halt;

  logic [INST_W-1:0] inst_out;
  logic              pcNop;
  logic              issue;
  logic              halted;
  logic [OCC_W-1:0]  sb_occ;

  modport master (
    output inst_in, inst_vld, rs_idx, rs_use, rt_idx, rt_use,
           wr_idx, wr_en, is_load, is_ctrl, is_halt,
    input  inst_out, pcNop, issue, halted, sb_occ
  );

  modport slave (
    input  inst_in, inst_vld, rs_idx, rs_use, rt_idx, rt_use,
           wr_idx, wr_en, is_load, is_ctrl, is_halt,
    output inst_out, pcNop, issue, halted, sb_occ
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Sits between fetch and decode. Every issued register write is pushed
//   into a DEPTH-entry shift register that mirrors the D/X/M stages; an
//   incoming instruction whose sources hit an in-flight write is held
//   (pcNop) and a NOP is sent to decode instead.
//
//   FWD_EN = 0 : full interlock, any in-flight write to a source stalls.
//   FWD_EN = 1 : forwarding exists, only a load in the youngest entry stalls.
//
//   After an issued control instruction, BR_PENALTY cycles of shadow block
//   issue. An issued HALT latches 'halted' until reset.
//
//   Ports:
//     clk   clock
//     rst   asynchronous, active-low reset
//     bus   hazard_scoreboard_if.slave (instruction in, decode-side out)
module hazard_scoreboard #(
  parameter int                INST_W     = 16,
  parameter int                REG_W      = 3,
  parameter int                DEPTH      = 3,
  parameter int                FWD_EN     = 0,
  parameter int                BR_PENALTY = 4,
  parameter logic [INST_W-1:0] NOP        = INST_W'(16'h0800)
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  // A zero-length shadow still needs a 1-bit counter so the logic stays legal.
  localparam int SHD_W = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;

  // Scoreboard entries: index 0 is the youngest (instruction now in D).
  logic [DEPTH-1:0] sb_v_q, sb_v_d;
  logic [REG_W-1:0] sb_idx_q [DEPTH];
  logic [REG_W-1:0] sb_idx_d [DEPTH];
  logic             sb_ld_q  [DEPTH];
  logic             sb_ld_d  [DEPTH];

  logic [SHD_W-1:0] shd_cnt_q, shd_cnt_d;
  logic             halted_q, halted_d;

  logic             rs_hit;
  logic             rt_hit;
  logic             raw;
  logic             shd_active;
  logic             stall;
  logic             issue;
  logic [OCC_W-1:0] occ;

  // RAW detection. Only older instructions sit in the scoreboard, so an
  // instruction that reads its own destination never matches itself.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    if (FWD_EN != 0) begin
      // With forwarding, only a load result one stage ahead is unavailable.
      rs_hit = sb_v_q[0] & sb_ld_q[0] & (sb_idx_q[0] == bus.rs_idx);
      rt_hit = sb_v_q[0] & sb_ld_q[0] & (sb_idx_q[0] == bus.rt_idx);
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        rs_hit = rs_hit | (sb_v_q[k] & (sb_idx_q[k] == bus.rs_idx));
        rt_hit = rt_hit | (sb_v_q[k] & (sb_idx_q[k] == bus.rt_idx));
      end
    end
    raw = (bus.rs_use & rs_hit) | (bus.rt_use & rt_hit);
  end

  // Issue decision. rst gates the outputs so nothing issues while reset
  // is held, even though the cleared state alone would allow it.
  always_comb begin
    shd_active = (shd_cnt_q != '0);
    stall      = bus.inst_vld & (raw | shd_active | halted_q);
    issue      = rst & bus.inst_vld & ~stall;
  end

  // Occupancy is a plain population count of the valid bits.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(sb_v_q[k]);
    end
  end

  always_comb begin
    bus.pcNop    = rst & stall;
    bus.issue    = issue;
    bus.inst_out = issue ? bus.inst_in : NOP;
    bus.halted   = halted_q;
    bus.sb_occ   = rst ? occ : '0;
  end

  // Next state: the scoreboard shifts every cycle; a cycle that does not
  // issue a write pushes an invalid entry, which is how bubbles age out.
  always_comb begin
    sb_v_d[0]   = issue & bus.wr_en;
    sb_idx_d[0] = bus.wr_idx;
    sb_ld_d[0]  = bus.is_load;
    for (int k = 1; k < DEPTH; k++) begin
      sb_v_d[k]   = sb_v_q[k-1];
      sb_idx_d[k] = sb_idx_q[k-1];
      sb_ld_d[k]  = sb_ld_q[k-1];
    end

    // A control op cannot issue during the shadow, so load and decrement
    // never compete. The count keeps draining while fetch is idle.
    shd_cnt_d = shd_cnt_q;
    if (issue & bus.is_ctrl) begin
      shd_cnt_d = SHD_W'(BR_PENALTY);
    end else if (shd_active) begin
      shd_cnt_d = shd_cnt_q - 1'b1;
    end

    halted_d = halted_q | (issue & bus.is_halt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v_q    <= '0;
      shd_cnt_q <= '0;
      halted_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        sb_idx_q[k] <= '0;
        sb_ld_q[k]  <= 1'b0;
      end
    end else begin
      sb_v_q    <= sb_v_d;
      shd_cnt_q <= shd_cnt_d;
      halted_q  <= halted_d;
      for (int k = 0; k < DEPTH; k++) begin
        sb_idx_q[k] <= sb_idx_d[k];
        sb_ld_q[k]  <= sb_ld_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. Three instances share clock and
//   reset: u0 (interlock, DEPTH=3), u1 (forwarding, DEPTH=3) and
//   u2 (interlock, DEPTH=5). Inputs change 1 time unit after the rising
//   edge and outputs are checked 1 unit later.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic        vld;
    logic [15:0] inst;
    logic [2:0]  rs;
    logic        rsu;
    logic [2:0]  rt;
    logic        rtu;
    logic [2:0]  wr;
    logic        we;
    logic        ld;
    logic        ctrl;
    logic        halt;
  } stim_t;

  localparam stim_t IDLE = '0;
  localparam logic [15:0] NOP = 16'h0800;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  stim_t in0 = IDLE;
  stim_t in1 = IDLE;
  stim_t in2 = IDLE;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.INST_W(16), .REG_W(3), .DEPTH(3)) if0 ();
  hazard_scoreboard_if #(.INST_W(16), .REG_W(3), .DEPTH(3)) if1 ();
  hazard_scoreboard_if #(.INST_W(16), .REG_W(3), .DEPTH(5)) if2 ();

  assign if0.inst_vld = in0.vld;  assign if0.inst_in = in0.inst;
  assign if0.rs_idx   = in0.rs;   assign if0.rs_use  = in0.rsu;
  assign if0.rt_idx   = in0.rt;   assign if0.rt_use  = in0.rtu;
  assign if0.wr_idx   = in0.wr;   assign if0.wr_en   = in0.we;
  assign if0.is_load  = in0.ld;   assign if0.is_ctrl = in0.ctrl;
  assign if0.is_halt  = in0.halt;

  assign if1.inst_vld = in1.vld;  assign if1.inst_in = in1.inst;
  assign if1.rs_idx   = in1.rs;   assign if1.rs_use  = in1.rsu;
  assign if1.rt_idx   = in1.rt;   assign if1.rt_use  = in1.rtu;
  assign if1.wr_idx   = in1.wr;   assign if1.wr_en   = in1.we;
  assign if1.is_load  = in1.ld;   assign if1.is_ctrl = in1.ctrl;
  assign if1.is_halt  = in1.halt;

  assign if2.inst_vld = in2.vld;  assign if2.inst_in = in2.inst;
  assign if2.rs_idx   = in2.rs;   assign if2.rs_use  = in2.rsu;
  assign if2.rt_idx   = in2.rt;   assign if2.rt_use  = in2.rtu;
  assign if2.wr_idx   = in2.wr;   assign if2.wr_en   = in2.we;
  assign if2.is_load  = in2.ld;   assign if2.is_ctrl = in2.ctrl;
  assign if2.is_halt  = in2.halt;

  hazard_scoreboard #(.DEPTH(3), .FWD_EN(0), .BR_PENALTY(4)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .BR_PENALTY(4)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  hazard_scoreboard #(.DEPTH(5), .FWD_EN(0), .BR_PENALTY(4)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  // Builds one valid instruction vector.
  function automatic stim_t make_op(logic [15:0] inst,
                                    logic [2:0] rs, logic rsu,
                                    logic [2:0] rt, logic rtu,
                                    logic [2:0] wr, logic we,
                                    logic ld, logic ctrl, logic halt);
    stim_t s;
    s.vld = 1'b1; s.inst = inst;
    s.rs = rs; s.rsu = rsu; s.rt = rt; s.rtu = rtu;
    s.wr = wr; s.we = we; s.ld = ld; s.ctrl = ctrl; s.halt = halt;
    return s;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] start");

    // Reset held with a valid instruction present: nothing may issue.
    in0 = make_op(16'h1234, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    #1;
    check_output("rst_inst_out", 32'(if0.inst_out), 32'h0800);
    check_output("rst_pcNop",    32'(if0.pcNop),    32'd0);
    check_output("rst_issue",    32'(if0.issue),    32'd0);
    check_output("rst_sb_occ",   32'(if0.sb_occ),   32'd0);
    check_output("rst_halted",   32'(if0.halted),   32'd0);
    in0 = IDLE;
    rst = 1'b1;
    next_cycle();

    // Interlock: ADD R3 at t, reader of R3 stalls t+1..t+3, issues at t+4.
    in0 = make_op(16'h1163, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("il_prod_issue", 32'(if0.issue), 32'd1);
    next_cycle();
    in0 = make_op(16'h2B00, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      check_output("il_stall_pcNop", 32'(if0.pcNop),    32'd1);
      check_output("il_stall_issue", 32'(if0.issue),    32'd0);
      check_output("il_stall_inst",  32'(if0.inst_out), 32'(NOP));
      check_output("il_stall_occ",   32'(if0.sb_occ),   32'd1);
      next_cycle();
    end
    #1;
    check_output("il_t4_pcNop", 32'(if0.pcNop),    32'd0);
    check_output("il_t4_issue", 32'(if0.issue),    32'd1);
    check_output("il_t4_inst",  32'(if0.inst_out), 32'h2B00);
    check_output("il_t4_occ",   32'(if0.sb_occ),   32'd0);
    next_cycle();
    in0 = IDLE;
    next_cycle();

    // Branch shadow with inst_vld toggling: 4 shadow cycles, issue at t+5.
    in0 = make_op(16'h6004, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check_output("br_issue", 32'(if0.issue), 32'd1);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      in0 = (i % 2 == 1) ?
            make_op(16'h1111, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0) :
            IDLE;
      #1;
      check_output("br_shd_pcNop", 32'(if0.pcNop),    (i % 2 == 1) ? 32'd1 : 32'd0);
      check_output("br_shd_issue", 32'(if0.issue),    32'd0);
      check_output("br_shd_inst",  32'(if0.inst_out), 32'(NOP));
      next_cycle();
    end
    in0 = make_op(16'h1111, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("br_t5_issue", 32'(if0.issue),    32'd1);
    check_output("br_t5_inst",  32'(if0.inst_out), 32'h1111);
    next_cycle();

    // Reset asserted in the middle of an interlock stall.
    in0 = make_op(16'h1163, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    in0 = make_op(16'h2B00, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("mr_pre_pcNop", 32'(if0.pcNop), 32'd1);
    rst = 1'b0;
    #1;
    check_output("mr_inst_out", 32'(if0.inst_out), 32'h0800);
    check_output("mr_pcNop",    32'(if0.pcNop),    32'd0);
    check_output("mr_issue",    32'(if0.issue),    32'd0);
    check_output("mr_sb_occ",   32'(if0.sb_occ),   32'd0);
    rst = 1'b1;
    in0 = make_op(16'h3333, 3'd5, 1'b1, 3'd6, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("mr_post_issue", 32'(if0.issue),    32'd1);
    check_output("mr_post_inst",  32'(if0.inst_out), 32'h3333);
    next_cycle();

    // HALT: latched from the next cycle, blocks everything until reset.
    in0 = make_op(16'hF000, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_output("ht_issue",  32'(if0.issue),  32'd1);
    check_output("ht_halted", 32'(if0.halted), 32'd0);
    next_cycle();
    in0 = make_op(16'h4444, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check_output("ht_halted_set", 32'(if0.halted),   32'd1);
      check_output("ht_pcNop",      32'(if0.pcNop),    32'd1);
      check_output("ht_inst",       32'(if0.inst_out), 32'(NOP));
      next_cycle();
    end
    rst = 1'b0;
    #1;
    check_output("ht_rst_halted", 32'(if0.halted), 32'd0);
    rst = 1'b1;
    #1;
    check_output("ht_rel_issue", 32'(if0.issue), 32'd1);
    next_cycle();
    in0 = IDLE;
    next_cycle();

    // Forwarding: load-use costs one stall, ALU producer costs none.
    in1 = make_op(16'h8A00, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_output("fw_ld_issue", 32'(if1.issue), 32'd1);
    next_cycle();
    in1 = make_op(16'h2050, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("fw_lu_pcNop", 32'(if1.pcNop), 32'd1);
    check_output("fw_lu_issue", 32'(if1.issue), 32'd0);
    next_cycle();
    #1;
    check_output("fw_lu2_pcNop", 32'(if1.pcNop),    32'd0);
    check_output("fw_lu2_inst",  32'(if1.inst_out), 32'h2050);
    next_cycle();
    in1 = make_op(16'h1A00, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("fw_alu_issue", 32'(if1.issue), 32'd1);
    next_cycle();
    in1 = make_op(16'h2051, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("fw_alu_rd_pcNop", 32'(if1.pcNop), 32'd0);
    check_output("fw_alu_rd_issue", 32'(if1.issue), 32'd1);
    next_cycle();
    // Self-dependent load (reads and writes R5) never stalls on itself.
    in1 = make_op(16'h8D50, 3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_output("fw_self_issue", 32'(if1.issue), 32'd1);
    next_cycle();
    in1 = IDLE;
    next_cycle();

    // DEPTH=5: producer R7, two independents, reader sees producer in SB[2]
    // and stalls while it occupies SB[2], SB[3], SB[4].
    in2 = make_op(16'h17E0, 3'd1, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("d5_prod_issue", 32'(if2.issue), 32'd1);
    next_cycle();
    in2 = make_op(16'h1001, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("d5_ind1_issue", 32'(if2.issue), 32'd1);
    next_cycle();
    in2 = make_op(16'h1002, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("d5_ind2_issue", 32'(if2.issue), 32'd1);
    next_cycle();
    in2 = make_op(16'h2E00, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("d5_stall_pcNop", 32'(if2.pcNop),  32'd1);
      check_output("d5_stall_occ",   32'(if2.sb_occ), 32'd1);
      next_cycle();
    end
    #1;
    check_output("d5_rd_issue", 32'(if2.issue),    32'd1);
    check_output("d5_rd_inst",  32'(if2.inst_out), 32'h2E00);
    next_cycle();
    in2 = make_op(16'h17E1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    // Matching rs index but rs_use=0 must not stall.
    in2 = make_op(16'h2E01, 3'd7, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("d5_nouse_pcNop", 32'(if2.pcNop), 32'd0);
    check_output("d5_nouse_issue", 32'(if2.issue), 32'd1);
    next_cycle();
    in2 = IDLE;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
